// File: rtl/c17_pipe_ctrl_pkg.sv
// Shared types and widths for the c17 pipeline controller.
package c17_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int VEC_W = 5;
  localparam int RES_W = 2;
  localparam int CNT_W = 16;

endpackage

// File: rtl/c17_pipe_ctrl_if.sv
// Requester-side bus: request handshake plus the one-hot response return.
interface c17_pipe_ctrl_if
  import c17_pipe_ctrl_pkg::*;
#(
  parameter int NREQ = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [VEC_W*NREQ-1:0] req_vec;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       rsp_valid;
  logic [RES_W-1:0]      rsp_data;

  modport master (output req_valid, req_vec, input req_ready, rsp_valid, rsp_data);
  modport slave  (input req_valid, req_vec, output req_ready, rsp_valid, rsp_data);
endinterface

// File: rtl/c17_pipe_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches from the requester after the last winner and
// moves its pointer only when the caller reports an accepted grant.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] ptr_q, ptr_d, win_s, cand_s;
  logic [SUM_W-1:0] sum_s;
  logic             found_s, hit_s;

  always_comb begin
    grant   = '0;
    win_s   = ptr_q;
    found_s = 1'b0;
    hit_s   = 1'b0;
    sum_s   = '0;
    cand_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sum_s  = {1'b0, ptr_q} + SUM_W'(i);
      cand_s = (sum_s >= SUM_W'(NREQ)) ? IDX_W'(sum_s - SUM_W'(NREQ)) : IDX_W'(sum_s);
      hit_s  = !found_s && req[cand_s];
      grant[cand_s] = grant[cand_s] | hit_s;
      win_s   = hit_s ? cand_s : win_s;
      found_s = found_s | hit_s;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (win_s == IDX_W'(NREQ - 1)) ? '0 : win_s + IDX_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/c17_pipe_ctrl.sv
// c17_pipe_ctrl: shares one pipelined c17 datapath among NREQ requesters and
// routes each result back to its issuer in issue order.
module c17_pipe_ctrl
  import c17_pipe_ctrl_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  c17_pipe_ctrl_if.slave   req_if,
  output logic [VEC_W-1:0] dp_in,
  input  logic [RES_W-1:0] dp_out,
  input  logic             drain,
  output logic             idle,
  output logic [CNT_W-1:0] issue_cnt
);
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [NREQ-1:0]   arb_req_s, grant_s;
  logic              grant_en_s, xfer_s, pipe_empty_s;
  logic [VEC_W-1:0]  sel_vec_s, dp_in_q, dp_in_d;
  logic [IDX_W-1:0]  sel_id_s;
  logic [PIPE_LAT:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]  tag_id_q [PIPE_LAT+1];
  logic [IDX_W-1:0]  tag_id_d [PIPE_LAT+1];
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0]  rsp_data_q, rsp_data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  // Drain wins over a same-cycle request, so it closes the grant gate directly.
  assign grant_en_s   = !rst && !drain && (state_q != ST_DRAIN);
  assign arb_req_s    = req_if.req_valid & {NREQ{grant_en_s}};
  assign xfer_s       = |grant_s;
  assign pipe_empty_s = ~|tag_vld_q;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (arb_req_s),
    .advance (xfer_s),
    .grant   (grant_s)
  );

  always_comb begin
    sel_vec_s = '0;
    sel_id_s  = '0;
    for (int i = 0; i < NREQ; i++) begin
      sel_vec_s = sel_vec_s | (req_if.req_vec[i*VEC_W +: VEC_W] & {VEC_W{grant_s[i]}});
      sel_id_s  = sel_id_s | (IDX_W'(i) & {IDX_W{grant_s[i]}});
    end
  end

  always_comb begin
    dp_in_d     = xfer_s ? sel_vec_s : dp_in_q;
    cnt_d       = xfer_s ? cnt_q + CNT_W'(1) : cnt_q;
    tag_vld_d   = {tag_vld_q[PIPE_LAT-1:0], xfer_s};
    tag_id_d[0] = sel_id_s;
    for (int j = 1; j <= PIPE_LAT; j++) begin
      tag_id_d[j] = tag_id_q[j-1];
    end
    // The last tag stage lines up with dp_out, so it qualifies the response.
    rsp_valid_d = tag_vld_q[PIPE_LAT] ? (NREQ'(1) << tag_id_q[PIPE_LAT]) : '0;
    rsp_data_d  = tag_vld_q[PIPE_LAT] ? dp_out : rsp_data_q;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (drain)                       state_d = ST_DRAIN;
        else if (|req_if.req_valid)      state_d = ST_RUN;
        else                             state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (drain)                                    state_d = ST_DRAIN;
        else if (!(|req_if.req_valid) && pipe_empty_s) state_d = ST_IDLE;
        else                                          state_d = ST_RUN;
      end
      ST_DRAIN: begin
        if (!drain && pipe_empty_s) state_d = ST_IDLE;
        else                        state_d = ST_DRAIN;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      dp_in_q     <= '0;
      cnt_q       <= '0;
      tag_vld_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      for (int j = 0; j <= PIPE_LAT; j++) tag_id_q[j] <= '0;
    end else begin
      state_q     <= state_d;
      dp_in_q     <= dp_in_d;
      cnt_q       <= cnt_d;
      tag_vld_q   <= tag_vld_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      for (int j = 0; j <= PIPE_LAT; j++) tag_id_q[j] <= tag_id_d[j];
    end
  end

  assign req_if.req_ready = grant_s;
  assign req_if.rsp_valid = rsp_valid_q;
  assign req_if.rsp_data  = rsp_data_q;
  assign dp_in            = dp_in_q;
  assign idle             = (state_q == ST_IDLE);
  assign issue_cnt        = cnt_q;

endmodule

// File: doc/c17_pipe_ctrl.md
C17_PIPE_CTRL -- requirements
Module: c17_pipe_ctrl

Interface
REQ-001 Parameter NREQ, default 2: number of requesters sharing one pipelined c17 datapath.
REQ-002 Parameter PIPE_LAT, default 2: datapath latency in clocks from dp_in to the matching dp_out.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  synchronous, active-high reset.
REQ-005 Port req_valid  input  NREQ  per-requester request valid.
REQ-006 Port req_vec  input  5*NREQ  per-requester vector; slice i is {N1,N2,N3,N6,N7}, N1 at the MSB.
REQ-007 Port req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-008 Port dp_in  output  5  registered drive to the datapath {N1,N2,N3,N6,N7}.
REQ-009 Port dp_out  input  2  datapath result {N22,N23}.
REQ-010 Port rsp_valid  output  NREQ  one-hot, one-cycle pulse that returns a result to its requester.
REQ-011 Port rsp_data  output  2  registered {N22,N23} qualified by rsp_valid.
REQ-012 Port drain  input  1  stops new grants and flushes in-flight work.
REQ-013 Port idle  output  1  high only in state IDLE.
REQ-014 Port issue_cnt  output  16  count of accepted transfers.

Function
REQ-015 At most one req_ready bit SHALL be high per cycle; no bit SHALL be high while the state is DRAIN.
REQ-016 Arbitration SHALL be round-robin: the search starts at the requester after the last granted one, and the pointer moves only on a transfer.
REQ-017 req_ready SHALL depend on req_valid and the state only; grants SHALL never go to an invalid requester.
REQ-018 On a transfer at edge k, dp_in SHALL take the vector at edge k; with no transfer, dp_in SHALL hold its value.
REQ-019 A tag shift register of depth PIPE_LAT+1 SHALL carry {valid, requester id} aligned with dp_in.
REQ-020 The result of a transfer at edge k SHALL appear with rsp_valid[id]=1 and rsp_data=dp_out-sample in the cycle after edge k+PIPE_LAT+1, giving a total latency of PIPE_LAT+2 clocks.
REQ-021 Throughput SHALL be one transfer per cycle; responses SHALL return in issue order, with no response backpressure.
REQ-022 The FSM states SHALL be IDLE, RUN and DRAIN.
REQ-023 IDLE->RUN SHALL occur on any req_valid with drain low.
REQ-024 RUN->IDLE SHALL occur when there is no req_valid and the tag pipe is empty.
REQ-025 RUN or IDLE->DRAIN SHALL occur on drain high.
REQ-026 DRAIN->IDLE SHALL occur when drain is low and the tag pipe is empty; otherwise the state SHALL stay in DRAIN.
REQ-027 In-flight tags SHALL still produce responses during DRAIN.
REQ-028 A request and drain asserted in the same cycle SHALL resolve to drain: no grant.
REQ-029 issue_cnt SHALL increment once per transfer and wrap from 16'hFFFF to 0.

Reset
REQ-030 rst SHALL force state IDLE, req_ready=0, dp_in=0, rsp_valid=0, rsp_data=0, issue_cnt=0, the RR pointer to requester 0, and all tags invalid.
REQ-031 A reset mid-operation SHALL discard all in-flight results, with no rsp_valid in the PIPE_LAT+2 cycles after reset.
REQ-032 rst SHALL take priority over drain and all requests.

Structure
REQ-033 A shared package SHALL hold the state enum (IDLE/RUN/DRAIN), VEC_W=5, RES_W=2 and CNT_W=16.
REQ-034 The round-robin arbiter SHALL be one sub-module, rr_arbiter (NREQ, req, advance -> grant).

Verification
REQ-035 Single request: req0 sends 10101 -> dp_in=10101 the next cycle, and rsp_valid=01 with rsp_data=11 four cycles after the handshake (PIPE_LAT=2).
REQ-036 Back-to-back: req0 sends 10101 then 10011 -> responses 11 then 01 on consecutive cycles, with issue_cnt=2.
REQ-037 Contention: both valid for 4 cycles -> grants alternate 0,1,0,1, and each rsp_valid matches its issuing requester.
REQ-038 Drain: drain raised with 2 in flight -> req_ready stays 0, both responses still return, and idle rises after drain falls.
REQ-039 Reset mid-flight: rst with 2 in flight -> no rsp_valid for 4 cycles, and issue_cnt=0.
REQ-040 Wrap: preload issue_cnt to 16'hFFFF, then one transfer -> issue_cnt=0.
